touchpad_controller: RTL and testbench
======================================

TOUCHPAD_CONTROLLER -- requirements
Module: touchpad_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, cclk cycles per touch_clk half-period (minimum 2).
REQ-002 SHALL have port cclk, input, 1, system clock; all logic is on the rising edge.
REQ-003 SHALL have port rstb, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port char, input, 1, sampling enable (level); high requests continuous X/Y/Z acquisition.
REQ-005 SHALL have port touch_busy, input, 1, converter BUSY line from the touch ADC (ADS7843-style).
REQ-006 SHALL have port data_in, input, 1, serial data from the ADC (DOUT).
REQ-007 SHALL have port touch_clk, output, 1, serial clock to the ADC (DCLK).
REQ-008 SHALL have port data_out, output, 1, serial command to the ADC (DIN).
REQ-009 SHALL have port touch_csb, output, 1, active-low chip select.
REQ-010 SHALL have ports x, y, z, output, 12 each, last converted X, Y, Z1 samples.

Function
REQ-011 SHALL derive a tick every CLK_DIV cclk cycles; touch_clk toggles only on ticks, and only while a frame is active.
REQ-012 SHALL implement the states IDLE, SETUP, CMD, READ, DONE.
REQ-013 IDLE: csb=1, touch_clk=0, data_out=0; go to SETUP on a tick when char=1 and touch_busy=0; stay in IDLE while touch_busy=1.
REQ-014 SETUP: csb=0 for one tick period, with data_out holding command bit 7; then go to CMD.
REQ-015 CMD: clock out 8 command bits, MSB first; data_out changes on touch_clk falling edges and is stable on rising edges.
REQ-016 The commands SHALL be X=0xD0, Y=0x90, Z1=0xB0 (start bit, 12-bit mode, differential, PD=00).
REQ-017 READ: issue 16 further touch_clk pulses with data_out=0.
REQ-018 In READ, data_in SHALL be sampled on each touch_clk rising edge.
REQ-019 The first READ pulse is the busy slot and is discarded; pulses 2-13 form the result MSB first; pulses 14-16 are discarded.
REQ-020 A frame SHALL be exactly 24 touch_clk pulses while csb is low.
REQ-021 DONE: drive csb=1 and touch_clk=0, and load the 12-bit result into the output register of the current channel only, in the same cclk cycle csb rises.
REQ-022 After DONE, the channel SHALL advance X->Y->Z->X (wrap-around).
REQ-023 After DONE, if char=1 the controller returns to IDLE and starts the next frame on the next eligible tick (minimum one tick with csb high); if char=0 it stays in IDLE.
REQ-024 Deasserting char mid-frame SHALL NOT abort the frame; it completes, and its result is stored.
REQ-025 touch_busy SHALL be used only as the start gate (REQ-013); it is ignored during a frame.
REQ-026 x, y, z SHALL be stable between updates and never show partial shift-register contents.
REQ-027 The channel sequence SHALL restart at X after reset.

Reset
REQ-028 rstb=1 SHALL immediately force: state IDLE, touch_csb=1, touch_clk=0, data_out=0, x=y=z=0, channel=X, divider and bit counters 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no register update; after release, acquisition restarts at X.

Verification
REQ-030 Apply reset with char=0 -> csb=1, touch_clk=0, data_out=0, x=y=z=0x000; hold 1000 cycles -> no touch_clk activity.
REQ-031 With char=1, touch_busy=0 and an ADC model returning 0xABC on X -> data_out shows 1101_0000 on rising edges, 24 pulses per csb-low window, then x=0xABC with y and z unchanged.
REQ-032 Continuous run with the model returning X=0x123, Y=0x456, Z=0x789 -> frames ordered X, Y, Z, X; commands 0xD0, 0x90, 0xB0; x/y/z hold the respective values.
REQ-033 Hold touch_busy=1 with char=1 -> csb stays high; release touch_busy -> the frame starts on the next tick.
REQ-034 Drop char after the 5th pulse of a Y frame -> the frame completes, y is updated, then the controller stays idle.
REQ-035 Assert rstb during READ of a Z frame -> csb=1 and all outputs 0 immediately; after release, the first frame sends 0xD0.

Source files
------------

// File: rtl/touchpad_controller.sv
// Serial front-end for an ADS7843-style touch ADC: cycles X/Y/Z1 conversion frames.
// Each frame is 24 touch_clk pulses (8 command, 16 read); results land on csb rise.
module touchpad_controller #(
  parameter int CLK_DIV = 16
) (
  input  logic        cclk,
  input  logic        rstb,
  input  logic        char,
  input  logic        touch_busy,
  input  logic        data_in,
  output logic        touch_clk,
  output logic        data_out,
  output logic        touch_csb,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic [11:0] z
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, CMD, READ, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    chan_q, chan_d;
  logic [11:0]   sr_q, sr_d;
  logic [11:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  logic          tclk_q, tclk_d, dout_q, dout_d, csb_q, csb_d;
  logic          tick;
  logic [7:0]    cmd;
  logic [2:0]    cmd_idx;

  assign tick    = (div_q == DW'(CLK_DIV - 1));
  assign cmd_idx = 3'd6 - bit_cnt_q[2:0];

  always_comb begin
    case (chan_q)
      2'd0:    cmd = 8'hD0;
      2'd1:    cmd = 8'h90;
      default: cmd = 8'hB0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + DW'(1);
    bit_cnt_d = bit_cnt_q;
    chan_d    = chan_q;
    sr_d      = sr_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    tclk_d    = tclk_q;
    dout_d    = dout_q;
    csb_d     = csb_q;

    case (state_q)
      IDLE: begin
        csb_d  = 1'b1;
        tclk_d = 1'b0;
        dout_d = 1'b0;
        if (tick && char && !touch_busy) begin
          state_d = SETUP;
          csb_d   = 1'b0;
          dout_d  = cmd[7];
        end
      end
      SETUP: begin
        if (tick) begin
          state_d   = CMD;
          tclk_d    = 1'b1;
          bit_cnt_d = '0;
        end
      end
      CMD: begin
        // Command bits change only on the falling half so the ADC sees them stable on rise
        if (tick) begin
          if (tclk_q) begin
            tclk_d = 1'b0;
            if (bit_cnt_q == 4'd7) begin
              state_d   = READ;
              bit_cnt_d = '0;
              dout_d    = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              dout_d    = cmd[cmd_idx];
            end
          end else begin
            tclk_d = 1'b1;
          end
        end
      end
      READ: begin
        if (tick) begin
          if (!tclk_q) begin
            tclk_d = 1'b1;
            // Pulse 1 is the busy slot and pulses 14-16 are padding; keep only 2..13
            if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd12)
              sr_d = {sr_q[10:0], data_in};
          end else begin
            tclk_d = 1'b0;
            if (bit_cnt_q == 4'd15) begin
              state_d = DONE;
              csb_d   = 1'b1;
              case (chan_q)
                2'd0:    x_d = sr_q;
                2'd1:    y_d = sr_q;
                default: z_d = sr_q;
              endcase
              chan_d = (chan_q == 2'd2) ? 2'd0 : chan_q + 2'd1;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
      end
      DONE: begin
        csb_d  = 1'b1;
        tclk_d = 1'b0;
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cclk or posedge rstb) begin
    if (rstb) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      chan_q    <= 2'd0;
      sr_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      tclk_q    <= 1'b0;
      dout_q    <= 1'b0;
      csb_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      chan_q    <= chan_d;
      sr_q      <= sr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      tclk_q    <= tclk_d;
      dout_q    <= dout_d;
      csb_q     <= csb_d;
    end
  end

  assign touch_clk = tclk_q;
  assign data_out  = dout_q;
  assign touch_csb = csb_q;
  assign x         = x_q;
  assign y         = y_q;
  assign z         = z_q;

endmodule

// File: tb/tb_touchpad_controller.sv
// Directed bench for touchpad_controller with a behavioural ADS7843-style ADC model.
module tb_touchpad_controller;
  localparam int CLK_DIV = 4;

  logic        cclk = 1'b0;
  logic        rstb = 1'b1;
  logic        char = 1'b0;
  logic        touch_busy = 1'b0;
  logic        data_in = 1'b0;
  logic        touch_clk, data_out, touch_csb;
  logic [11:0] x, y, z;

  touchpad_controller #(.CLK_DIV(CLK_DIV)) dut (
    .cclk(cclk), .rstb(rstb), .char(char), .touch_busy(touch_busy), .data_in(data_in),
    .touch_clk(touch_clk), .data_out(data_out), .touch_csb(touch_csb),
    .x(x), .y(y), .z(z)
  );

  always #5 cclk = ~cclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ADC model state
  logic [11:0] val_x = '0, val_y = '0, val_z = '0;
  logic [7:0]  cmd_cur = '0;
  logic [11:0] mv;
  int          rd;
  int          pulses_cur = 0;
  int          tclk_rises = 0;
  int          csb_falls = 0;

  logic [7:0]  f_cmd[$];
  int          f_pulses[$];
  logic [11:0] f_x[$], f_y[$], f_z[$];

  function automatic logic [11:0] sel_val(input logic [7:0] c);
    case (c)
      8'hD0:   return val_x;
      8'h90:   return val_y;
      8'hB0:   return val_z;
      default: return 12'h000;
    endcase
  endfunction

  always @(posedge touch_clk) begin
    tclk_rises++;
    if (!touch_csb) begin
      pulses_cur++;
      if (pulses_cur <= 8) cmd_cur = {cmd_cur[6:0], data_out};
    end
  end

  // DOUT changes on falling DCLK; discarded slots are driven high to expose misalignment
  always @(negedge touch_clk) begin
    if (!touch_csb) begin
      rd = pulses_cur + 1 - 8;
      mv = sel_val(cmd_cur);
      if (rd >= 2 && rd <= 13) data_in = mv[13-rd];
      else if (rd == 1 || rd >= 14) data_in = 1'b1;
      else data_in = 1'b0;
    end
  end

  always @(negedge touch_csb) begin
    pulses_cur = 0;
    cmd_cur    = '0;
    data_in    = 1'b0;
    csb_falls++;
  end

  always @(posedge touch_csb) begin
    if (!rstb) begin
      #1;
      f_cmd.push_back(cmd_cur);
      f_pulses.push_back(pulses_cur);
      f_x.push_back(x);
      f_y.push_back(y);
      f_z.push_back(z);
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (f_cmd.size() < n && c < budget) begin
      @(posedge cclk);
      c++;
    end
    check("frame_timeout", 32'(f_cmd.size() >= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_csb"}, 32'(touch_csb), 32'd1);
    check({tag, "_tclk"}, 32'(touch_clk), 32'd0);
    check({tag, "_dout"}, 32'(data_out), 32'd0);
    check({tag, "_x"}, 32'(x), 32'h000);
    check({tag, "_y"}, 32'(y), 32'h000);
    check({tag, "_z"}, 32'(z), 32'h000);
  endtask

  initial begin
    int b, base, c;

    // Reset with char low, then a long quiet idle
    repeat (3) @(posedge cclk);
    #1 check_reset_outputs("rst");
    @(negedge cclk) rstb = 1'b0;
    base = tclk_rises;
    repeat (1000) @(posedge cclk);
    #1;
    check("idle_no_tclk", 32'(tclk_rises - base), 32'd0);
    check("idle_csb", 32'(touch_csb), 32'd1);

    // Single X frame
    val_x = 12'hABC;
    @(negedge cclk) char = 1'b1;
    c = 0;
    while (csb_falls < 1 && c < 200) begin @(posedge cclk); c++; end
    @(negedge cclk) char = 1'b0;
    wait_frames(1, 2000);
    if (f_cmd.size() >= 1) begin
      check("x_cmd", 32'(f_cmd[0]), 32'hD0);
      check("x_pulses", 32'(f_pulses[0]), 32'd24);
      check("x_at_csb_rise", 32'(f_x[0]), 32'hABC);
      check("x_y_unchanged", 32'(f_y[0]), 32'h000);
      check("x_z_unchanged", 32'(f_z[0]), 32'h000);
    end

    // Continuous run from reset: X, Y, Z, X
    @(negedge cclk) rstb = 1'b1;
    @(negedge cclk) rstb = 1'b0;
    check("rst2_x", 32'(x), 32'h000);
    val_x = 12'h123; val_y = 12'h456; val_z = 12'h789;
    b = f_cmd.size();
    char = 1'b1;
    wait_frames(b + 4, 6000);
    @(negedge cclk) char = 1'b0;
    if (f_cmd.size() >= b + 4) begin
      check("seq_cmd0", 32'(f_cmd[b]), 32'hD0);
      check("seq_cmd1", 32'(f_cmd[b+1]), 32'h90);
      check("seq_cmd2", 32'(f_cmd[b+2]), 32'hB0);
      check("seq_cmd3", 32'(f_cmd[b+3]), 32'hD0);
      check("seq_x0", 32'(f_x[b]), 32'h123);
      check("seq_y0_hold", 32'(f_y[b]), 32'h000);
      check("seq_y1", 32'(f_y[b+1]), 32'h456);
      check("seq_z2", 32'(f_z[b+2]), 32'h789);
      check("seq_pulses2", 32'(f_pulses[b+2]), 32'd24);
    end
    check("seq_x", 32'(x), 32'h123);
    check("seq_y", 32'(y), 32'h456);
    check("seq_z", 32'(z), 32'h789);

    // Busy gate: no frame while busy, start on the first tick after release
    repeat (300) @(posedge cclk);
    val_y = 12'h5A5;
    @(negedge cclk);
    base = csb_falls;
    touch_busy = 1'b1;
    char = 1'b1;
    repeat (300) @(negedge cclk);
    check("busy_hold", 32'(csb_falls - base), 32'd0);
    touch_busy = 1'b0;
    c = 0;
    while (touch_csb && c < 20) begin @(posedge cclk); #1; c++; end
    check("busy_release_start", 32'(c >= 1 && c <= CLK_DIV), 32'd1);

    // This is a Y frame: drop char after pulse 5, frame must still complete
    b = f_cmd.size();
    c = 0;
    while (pulses_cur < 5 && c < 500) begin @(posedge cclk); c++; end
    @(negedge cclk) char = 1'b0;
    wait_frames(b + 1, 2000);
    if (f_cmd.size() >= b + 1) begin
      check("drop_cmd", 32'(f_cmd[b]), 32'h90);
      check("drop_pulses", 32'(f_pulses[b]), 32'd24);
      check("drop_y", 32'(f_y[b]), 32'h5A5);
      check("drop_x_hold", 32'(f_x[b]), 32'h123);
    end
    base = csb_falls;
    repeat (500) @(posedge cclk);
    #1;
    check("drop_idle", 32'(csb_falls - base), 32'd0);
    check("drop_idle_csb", 32'(touch_csb), 32'd1);

    // Reset during READ of a Z frame
    val_z = 12'h3C3;
    base = csb_falls;
    @(negedge cclk) char = 1'b1;
    c = 0;
    while (!(csb_falls > base && pulses_cur >= 12) && c < 1000) begin @(posedge cclk); c++; end
    check("z_frame_cmd", 32'(cmd_cur), 32'hB0);
    b = f_cmd.size();
    @(negedge cclk) rstb = 1'b1;
    #1 check_reset_outputs("midrst");
    repeat (5) @(posedge cclk);
    check("midrst_no_store", 32'(f_cmd.size()), 32'(b));
    @(negedge cclk) rstb = 1'b0;
    wait_frames(b + 1, 2000);
    @(negedge cclk) char = 1'b0;
    if (f_cmd.size() >= b + 1) begin
      check("post_rst_cmd", 32'(f_cmd[b]), 32'hD0);
      check("post_rst_pulses", 32'(f_pulses[b]), 32'd24);
      check("post_rst_x", 32'(f_x[b]), 32'h123);
      check("post_rst_z", 32'(f_z[b]), 32'h000);
    end

    repeat (20) @(posedge cclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
